// File: rtl/stack_arbiter.sv
// Round-robin arbiter sharing one LIFO stack among NREQ requesters.
// One transaction in flight; illegal push/pop completes with an error response.
module stack_arbiter #(
   parameter int NREQ = 2,
   parameter int DW   = 8,
   parameter int RRW  = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req_valid,
   input  logic [NREQ-1:0]     req_op,
   input  logic [NREQ*DW-1:0]  req_data,
   output logic [NREQ-1:0]     req_ready,
   output logic [NREQ-1:0]     rsp_valid,
   output logic [DW-1:0]       rsp_data,
   output logic                rsp_err,
   output logic                stk_push,
   output logic                stk_pop,
   output logic [DW-1:0]       stk_din,
   input  logic [DW-1:0]       stk_dout,
   input  logic                stk_empty,
   input  logic                stk_full,
   output logic [1:0]          dbg_state
);

   // Handshake: a request transfers on a rising edge where req_valid[i] and
   // req_ready[i] are both high; rsp_valid is a one-cycle pulse with no backpressure.
   typedef enum logic [1:0] {IDLE, EXEC, WAIT, RESP} state_t;

   state_t           state;
   logic [RRW-1:0]   ptr;
   logic [RRW-1:0]   idx;
   logic [RRW-1:0]   win;
   logic             any;
   logic             op_q;
   logic [DW-1:0]    data_q;
   logic [DW-1:0]    din_q;
   logic             push_now;
   logic             pop_now;

   function automatic logic [NREQ-1:0] onehot(input logic [RRW-1:0] i);
      logic [NREQ-1:0] v;
      v = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (int'(i) == k) v[k] = 1'b1;
      end
      return v;
   endfunction

   // Walk downward so the last hit is the nearest requester after ptr.
   always_comb begin
      any = 1'b0;
      win = ptr;
      for (int k = NREQ; k >= 1; k--) begin
         if (req_valid[(int'(ptr) + k) % NREQ]) begin
            any = 1'b1;
            win = RRW'((int'(ptr) + k) % NREQ);
         end
      end
   end

   assign req_ready = (state == IDLE && !rst && any) ? onehot(win) : '0;

   // Strobes decode the EXEC state against the live flags, so the flags
   // are judged in EXEC and the strobe lasts exactly that one cycle.
   assign push_now  = (state == EXEC) && !rst && op_q && !stk_full;
   assign pop_now   = (state == EXEC) && !rst && !op_q && !stk_empty;
   assign stk_push  = push_now;
   assign stk_pop   = pop_now;
   assign stk_din   = push_now ? data_q : din_q;
   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= RRW'(NREQ - 1);
         idx       <= '0;
         op_q      <= 1'b0;
         data_q    <= '0;
         din_q     <= '0;
         rsp_valid <= '0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any) begin
                  idx    <= win;
                  op_q   <= req_op[win];
                  data_q <= req_data[int'(win)*DW +: DW];
                  state  <= EXEC;
               end
            end
            EXEC: begin
               if (op_q && !stk_full) din_q <= data_q;
               if (!op_q && !stk_empty) begin
                  state <= WAIT;
               end else begin
                  rsp_valid <= onehot(idx);
                  rsp_err   <= op_q ? stk_full : 1'b1;
                  rsp_data  <= '0;
                  state     <= RESP;
               end
            end
            WAIT: begin
               rsp_valid <= onehot(idx);
               rsp_data  <= stk_dout;
               rsp_err   <= 1'b0;
               state     <= RESP;
            end
            RESP: begin
               rsp_valid <= '0;
               rsp_data  <= '0;
               rsp_err   <= 1'b0;
               ptr       <= idx;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_stack_arbiter.sv
// Bench for stack_arbiter: 4-deep stack model, reference LIFO and
// round-robin model, scoreboard queues checked by a negedge monitor.
module tb_stack_arbiter;
   localparam int NREQ  = 2;
   localparam int DW    = 8;
   localparam int RRW   = 3;
   localparam int DEPTH = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NREQ-1:0]   req_valid = '0;
   logic [NREQ-1:0]   req_op = '0;
   logic [NREQ*DW-1:0] req_data = '0;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ-1:0]   rsp_valid;
   logic [DW-1:0]     rsp_data;
   logic              rsp_err;
   logic              stk_push;
   logic              stk_pop;
   logic [DW-1:0]     stk_din;
   logic [DW-1:0]     stk_dout = '0;
   logic              stk_empty;
   logic              stk_full;
   logic [1:0]        dbg_state;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   // Scoreboard entries: {cycle[31:0], idx[3:0], err, 3'b0, data[7:0]}
   logic [47:0] exp_q[$];
   // Strobe entries: {cycle[31:0], is_push, din[7:0]}
   logic [40:0] stb_q[$];
   logic [DW-1:0] ref_q[$];
   logic [DW-1:0] env_q[$];
   int env_n = 0;
   int mptr = NREQ - 1;
   logic [DW-1:0] last_din = '0;
   int g_log[$];

   stack_arbiter #(.NREQ(NREQ), .DW(DW), .RRW(RRW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_op(req_op), .req_data(req_data),
      .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .stk_push(stk_push), .stk_pop(stk_pop), .stk_din(stk_din),
      .stk_dout(stk_dout), .stk_empty(stk_empty), .stk_full(stk_full),
      .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- stack environment ----------------
   assign stk_full  = (env_n == DEPTH);
   assign stk_empty = (env_n == 0);

   always @(posedge clk) begin
      if (stk_push && env_q.size() < DEPTH) env_q.push_back(stk_din);
      if (stk_pop && env_q.size() > 0) stk_dout <= env_q.pop_back();
      env_n <= env_q.size();
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic reset_model();
      exp_q.delete();
      stb_q.delete();
      mptr = NREQ - 1;
      last_din = '0;
   endtask

   // ---------------- driver ----------------
   task automatic req_issue(input int i, input logic op, input logic [7:0] d, input int hold);
      int  n;
      bit  got;
      req_op[i] = op;
      req_data[i*DW +: DW] = d;
      req_valid[i] = 1'b1;
      got = 0;
      n = 0;
      while (!got) begin
         @(negedge clk);
         if (req_ready[i]) got = 1;
         else begin
            n++;
            if (hold > 0 && n >= hold) break;
            if (n >= 200) begin
               chk("accept_timeout", 0, 1);
               break;
            end
         end
      end
      @(posedge clk);
      #1;
      req_valid[i] = 1'b0;
   endtask

   task automatic check_idle(input string nm);
      @(negedge clk);
      chk({nm, "_rsp_valid"}, rsp_valid, 0);
      chk({nm, "_rsp_data"}, rsp_data, 0);
      chk({nm, "_rsp_err"}, rsp_err, 0);
      chk({nm, "_stk_push"}, stk_push, 0);
      chk({nm, "_stk_pop"}, stk_pop, 0);
      chk({nm, "_stk_din"}, stk_din, 0);
      chk({nm, "_req_ready"}, req_ready, 0);
      chk({nm, "_state"}, dbg_state, 0);
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin : mon
      int g;
      int w;
      int j;
      logic op;
      logic err;
      logic [7:0] d;
      logic [7:0] v;
      logic [47:0] e;
      logic [40:0] s;
      if (!rst) begin
         if (req_ready != 0) begin
            chk("grant_onehot", $countones(req_ready), 1);
            g = 0;
            for (int k = NREQ - 1; k >= 0; k--) if (req_ready[k]) g = k;
            w = -1;
            for (int k = 1; k <= NREQ; k++) begin
               j = (mptr + k) % NREQ;
               if (w < 0 && req_valid[j]) w = j;
            end
            chk("grant_rr", g, w);
            g_log.push_back(g);
            op = req_op[g];
            d = req_data[g*DW +: DW];
            if (op) begin
               err = (ref_q.size() == DEPTH);
               if (!err) begin
                  ref_q.push_back(d);
                  stb_q.push_back({32'(cyc + 1), 1'b1, d});
               end
               exp_q.push_back({32'(cyc + 2), 4'(g), err, 3'b0, 8'h00});
            end else if (ref_q.size() == 0) begin
               exp_q.push_back({32'(cyc + 2), 4'(g), 1'b1, 3'b0, 8'h00});
            end else begin
               v = ref_q.pop_back();
               stb_q.push_back({32'(cyc + 1), 1'b0, 8'h00});
               exp_q.push_back({32'(cyc + 3), 4'(g), 1'b0, 3'b0, v});
            end
            mptr = g;
         end
         if (stk_push && stk_pop) chk("stk_both", 1, 0);
         if (stk_push || stk_pop) begin
            if (stb_q.size() == 0) chk("stk_unexpected", {stk_push, stk_pop}, 0);
            else begin
               s = stb_q.pop_front();
               chk("stk_cycle", cyc, s[40:9]);
               chk("stk_kind", stk_push, s[8]);
               if (s[8]) begin
                  chk("stk_din", stk_din, s[7:0]);
                  last_din = s[7:0];
               end
            end
         end else begin
            chk("stk_din_hold", stk_din, last_din);
         end
         if (rsp_valid != 0) begin
            if (exp_q.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
            else begin
               e = exp_q.pop_front();
               chk("rsp_cycle", cyc, e[47:16]);
               chk("rsp_valid", rsp_valid, NREQ'(1) << e[15:12]);
               chk("rsp_err", rsp_err, e[11]);
               chk("rsp_data", rsp_data, e[7:0]);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int n;
      rst = 1'b1;
      reset_model();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check_idle("post_reset");

      req_issue(0, 1'b1, 8'h11, 0);
      req_issue(0, 1'b0, 8'h00, 0);
      req_issue(1, 1'b0, 8'h00, 0);

      g_log.delete();
      fork
         begin
            req_issue(0, 1'b1, 8'h22, 0);
            req_issue(0, 1'b1, 8'h22, 0);
         end
         begin
            req_issue(1, 1'b1, 8'h33, 0);
            req_issue(1, 1'b1, 8'h33, 0);
         end
      join
      chk("alt_count", g_log.size(), 4);
      for (int k = 0; k < 4 && k < g_log.size(); k++) chk("alt_grant", g_log[k], k % 2);

      req_issue(1, 1'b1, 8'hAA, 0);
      req_issue(0, 1'b0, 8'h00, 0);
      req_issue(1, 1'b0, 8'h00, 0);

      // Reset lands while the pop sits in WAIT.
      req_issue(1, 1'b0, 8'h00, 0);
      @(posedge clk);
      #1 rst = 1'b1;
      reset_model();
      @(posedge clk);
      #1 rst = 1'b0;
      check_idle("mid_reset");
      g_log.delete();
      fork
         req_issue(0, 1'b1, 8'h55, 0);
         req_issue(1, 1'b1, 8'h66, 0);
      join
      chk("post_reset_first", (g_log.size() > 0) ? g_log[0] : -1, 0);

      fork
         for (int r = 0; r < NREQ; r++) begin
            automatic int rq = r;
            fork
               repeat (150) begin
                  repeat ($urandom_range(0, 3)) begin
                     @(posedge clk);
                     #1;
                  end
                  req_issue(rq, 1'(($urandom_range(0, 1))), 8'($urandom_range(0, 255)),
                            ($urandom_range(0, 7) == 0) ? 1 : 0);
               end
            join_none
         end
      join
      wait fork;

      n = 0;
      while ((exp_q.size() != 0 || stb_q.size() != 0) && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("drain", exp_q.size() + stb_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
